// File: rtl/dm_store_queue.sv
// dm_store_queue: posted-write store queue between the MEM stage and data memory.
// Holds up to DEPTH lane-aligned, byte-enabled stores in FIFO order, drains
// them over a req/ack handshake, flags loads that hit a pending store word and
// offers a sync/drain handshake for syscall/eret/exception boundaries.
// Optional macro STQ_MERGE_EN: a store to the youngest entry's word merges
// into it (only when that entry is not the head being presented to memory).
module dm_store_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [31:0]   st_addr,
  input  logic [3:0]    st_byteen,
  input  logic [31:0]   st_wdata,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  output logic          ld_hazard,
  input  logic          sync_req,
  output logic          sync_done,
  output logic          dm_req,
  output logic [31:0]   dm_addr,
  output logic [3:0]    dm_byteen,
  output logic [31:0]   dm_wdata,
  input  logic          dm_ack,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  // Entry payload (not reset: an entry is only meaningful while its valid is set)
  logic [29:0]      addr_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];

  // Control state
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic full;
  logic merge_hit;
  logic push;
  logic do_alloc;
  logic pop;
  logic addr_hit;

  // Byte offsets are irrelevant: everything is tracked per 32-bit word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign full = (count_q == CW'(DEPTH));

`ifdef STQ_MERGE_EN
  logic [PW-1:0] young;
  logic          do_merge;
  assign young = tail_q - PW'(1);
  // Youngest entry is only mergeable when it is not the head (count >= 2).
  assign merge_hit = st_valid && (st_byteen != 4'b0000) && (count_q >= CW'(2)) &&
                     (addr_q[young] == st_addr[31:2]);
  assign do_merge  = push && merge_hit;
`else
  assign merge_hit = 1'b0;
`endif

  // No same-cycle bypass: a full queue refuses even if a pop happens now.
  assign st_ready  = (!full || merge_hit) && !sync_req;
  assign push      = st_valid && st_ready && (st_byteen != 4'b0000);
  assign do_alloc  = push && !merge_hit;
  assign dm_req    = (count_q != '0);
  assign pop       = dm_req && dm_ack;

  assign dm_addr   = {addr_q[head_q], 2'b00};
  assign dm_byteen = be_q[head_q];
  assign dm_wdata  = data_q[head_q];
  assign sync_done = (count_q == '0);
  assign count     = count_q;

  // Load hazard: compare the load word against every pending (registered) entry.
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == ld_addr[31:2])) addr_hit = 1'b1;
    end
  end
  assign ld_hazard = ld_valid && addr_hit;

  // Next-state for pointers, valids and count from pop/allocate events.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    vld_d   = vld_q;
    count_d = count_q + {{(CW-1){1'b0}}, do_alloc} - {{(CW-1){1'b0}}, pop};
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (do_alloc) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
  end

  // Control registers; reset discards all pending entries and ignores dm_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  // Entry payload writes: allocate at tail, or merge lanes into the youngest entry.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      addr_q[tail_q] <= st_addr[31:2];
      be_q[tail_q]   <= st_byteen;
      data_q[tail_q] <= st_wdata;
    end
`ifdef STQ_MERGE_EN
    if (do_merge) begin
      be_q[young] <= be_q[young] | st_byteen;
      for (int b = 0; b < 4; b++) begin
        if (st_byteen[b]) data_q[young][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
`endif
  end

endmodule

// File: tb/tb_dm_store_queue.sv
// Self-checking bench for dm_store_queue: a FIFO-of-structs reference model
// compared every cycle, plus hand-computed literal checks along directed tests.
module tb_dm_store_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          reset;
  logic          st_valid;
  logic [31:0]   st_addr;
  logic [3:0]    st_byteen;
  logic [31:0]   st_wdata;
  logic          st_ready;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          ld_hazard;
  logic          sync_req;
  logic          sync_done;
  logic          dm_req;
  logic [31:0]   dm_addr;
  logic [3:0]    dm_byteen;
  logic [31:0]   dm_wdata;
  logic          dm_ack;
  logic [CW-1:0] count;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  dm_store_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_byteen(st_byteen), .st_wdata(st_wdata),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .sync_req(sync_req), .sync_done(sync_done),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_byteen(dm_byteen), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of pending stores ----------------
  typedef struct {
    logic [29:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];

  function automatic bit m_merge();
`ifdef STQ_MERGE_EN
    if (st_valid && st_byteen != 4'b0000 && mq.size() >= 2)
      return mq[mq.size()-1].a == st_addr[31:2];
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return (mq.size() != DEPTH || m_merge()) && !sync_req;
  endfunction

  function automatic bit m_hazard();
    if (!ld_valid) return 1'b0;
    foreach (mq[i]) if (mq[i].a == ld_addr[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  ent_t m_e;
  bit   m_acc, m_mg, m_pop;

  // Model state update on each active edge using the inputs held over the cycle.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
    end else begin
      m_acc = st_valid && m_ready() && (st_byteen != 4'b0000);
      m_mg  = m_acc && m_merge();
      m_pop = (mq.size() != 0) && dm_ack;
      if (m_mg) begin
        m_e = mq[mq.size()-1];
        m_e.be = m_e.be | st_byteen;
        for (int b = 0; b < 4; b++)
          if (st_byteen[b]) m_e.d[8*b +: 8] = st_wdata[8*b +: 8];
        mq[mq.size()-1] = m_e;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_acc && !m_mg) begin
        m_e.a  = st_addr[31:2];
        m_e.be = st_byteen;
        m_e.d  = st_wdata;
        mq.push_back(m_e);
      end
    end
  end

  // Compare DUT against model mid-cycle, every cycle after the first reset edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_dm_req", 32'(dm_req), 32'(mq.size() != 0));
      chk("m_sync_done", 32'(sync_done), 32'(mq.size() == 0));
      chk("m_st_ready", 32'(st_ready), 32'(m_ready()));
      chk("m_ld_hazard", 32'(ld_hazard), 32'(m_hazard()));
      if (mq.size() != 0) begin
        chk("m_dm_addr", dm_addr, {mq[0].a, 2'b00});
        chk("m_dm_byteen", 32'(dm_byteen), 32'(mq[0].be));
        chk("m_dm_wdata", dm_wdata, mq[0].d);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic v, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    st_valid  = v;
    st_addr   = a;
    st_byteen = be;
    st_wdata  = d;
  endtask

  task automatic push1(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    set_st(1'b1, a, be, d);
    tick();
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  logic [31:0] exp_a [4];
  logic [31:0] exp_d [4];
  int          e_cnt;
  logic [3:0]  e_be;
  logic [31:0] e_d;

  initial begin
    reset = 1'b1;
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    ld_valid = 1'b0; ld_addr = 32'h0; sync_req = 1'b0; dm_ack = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_ld_hazard", 32'(ld_hazard), 32'd0);
    chk("rst_sync_done", 32'(sync_done), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    // Single word store, held while unacknowledged, then drained.
    push1(32'h100, 4'b1111, 32'hDEADBEEF);
    #1;
    chk("t1_dm_req", 32'(dm_req), 32'd1);
    chk("t1_dm_addr", dm_addr, 32'h100);
    chk("t1_dm_byteen", 32'(dm_byteen), 32'hF);
    chk("t1_dm_wdata", dm_wdata, 32'hDEADBEEF);
    chk("t1_count", 32'(count), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_hold_addr", dm_addr, 32'h100);
      chk("t1_hold_data", dm_wdata, 32'hDEADBEEF);
    end
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    #1;
    chk("t1_count_after_ack", 32'(count), 32'd0);
    chk("t1_dm_req_after_ack", 32'(dm_req), 32'd0);

    // Fill to DEPTH, refuse a 5th even with a concurrent pop, then drain with wrap.
    for (int i = 0; i < 4; i++) push1(32'h400 + 32'(4*i), 4'b1111, 32'h1000 + 32'(i));
    set_st(1'b1, 32'h500, 4'b1111, 32'h5555);
    #1;
    chk("t2_full_ready", 32'(st_ready), 32'd0);
    chk("t2_full_count", 32'(count), 32'd4);
    tick();
    chk("t2_still_full", 32'(count), 32'd4);
    dm_ack = 1'b1;
    #1;
    chk("t2_no_bypass", 32'(st_ready), 32'd0);
    tick();
    dm_ack = 1'b0;
    #1;
    chk("t2_count_after_pop", 32'(count), 32'd3);
    chk("t2_ready_after_pop", 32'(st_ready), 32'd1);
    tick();
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("t2_refill_count", 32'(count), 32'd4);
    exp_a[0] = 32'h404; exp_a[1] = 32'h408; exp_a[2] = 32'h40C; exp_a[3] = 32'h500;
    exp_d[0] = 32'h1001; exp_d[1] = 32'h1002; exp_d[2] = 32'h1003; exp_d[3] = 32'h5555;
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain_addr", dm_addr, exp_a[k]);
      chk("t2_drain_data", dm_wdata, exp_d[k]);
      dm_ack = 1'b1;
      tick();
    end
    dm_ack = 1'b0;
    #1;
    chk("t2_drained", 32'(count), 32'd0);

    // Load hazard on a pending byte store; a same-cycle pop keeps it for that cycle.
    push1(32'h203, 4'b1000, 32'hAB000000);
    ld_valid = 1'b1;
    ld_addr  = 32'h200;
    #1;
    chk("t3_hazard_hit", 32'(ld_hazard), 32'd1);
    chk("t3_dm_addr", dm_addr, 32'h200);
    chk("t3_dm_byteen", 32'(dm_byteen), 32'h8);
    chk("t3_dm_wdata", dm_wdata, 32'hAB000000);
    ld_addr = 32'h204;
    #1;
    chk("t3_hazard_miss", 32'(ld_hazard), 32'd0);
    ld_addr = 32'h200;
    dm_ack  = 1'b1;
    #1;
    chk("t3_hazard_during_pop", 32'(ld_hazard), 32'd1);
    tick();
    dm_ack = 1'b0;
    #1;
    chk("t3_hazard_after_pop", 32'(ld_hazard), 32'd0);
    ld_valid = 1'b0;

    // Push and pop together at count 2; zero byteen is not a store.
    push1(32'h600, 4'b1111, 32'h6000);
    push1(32'h604, 4'b1111, 32'h6004);
    set_st(1'b1, 32'h608, 4'b1111, 32'h6008);
    dm_ack = 1'b1;
    tick();
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    dm_ack = 1'b0;
    #1;
    chk("t4_count_pushpop", 32'(count), 32'd2);
    chk("t4_head_after", dm_addr, 32'h604);
    push1(32'h60C, 4'b0000, 32'h600C);
    #1;
    chk("t4_zero_be_count", 32'(count), 32'd2);
    dm_ack = 1'b1;
    tick();
    chk("t4_second_addr", dm_addr, 32'h608);
    chk("t4_second_data", dm_wdata, 32'h6008);
    tick();
    dm_ack = 1'b0;
    #1;
    chk("t4_drained", 32'(count), 32'd0);

    // Sync: stores refused while draining continues until empty.
    push1(32'h700, 4'b1111, 32'h7000);
    push1(32'h704, 4'b1111, 32'h7004);
    push1(32'h708, 4'b1111, 32'h7008);
    set_st(1'b1, 32'h70C, 4'b1111, 32'h700C);
    sync_req = 1'b1;
    dm_ack   = 1'b1;
    #1;
    chk("t5_sync_ready", 32'(st_ready), 32'd0);
    chk("t5_sync_done_busy", 32'(sync_done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_sync_done", 32'(sync_done), (k == 2) ? 32'd1 : 32'd0);
    end
    chk("t5_count_empty", 32'(count), 32'd0);
    sync_req = 1'b0;
    dm_ack   = 1'b0;
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    chk("t5_refused_store", 32'(count), 32'd0);

    // Reset with pending entries discards them; ack and store in that cycle ignored.
    push1(32'h710, 4'b1111, 32'h7100);
    push1(32'h714, 4'b1111, 32'h7140);
    #1;
    chk("t6_count_before", 32'(count), 32'd2);
    reset  = 1'b1;
    dm_ack = 1'b1;
    set_st(1'b1, 32'h718, 4'b1111, 32'h7180);
    tick();
    reset  = 1'b0;
    dm_ack = 1'b0;
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("t6_count_reset", 32'(count), 32'd0);
    chk("t6_dm_req_reset", 32'(dm_req), 32'd0);
    chk("t6_sync_done_reset", 32'(sync_done), 32'd1);

    // Merge behind a non-head entry (only when the merge feature is built in).
`ifdef STQ_MERGE_EN
    e_cnt = 2; e_be = 4'b0111; e_d = 32'h00561234;
`else
    e_cnt = 3; e_be = 4'b0011; e_d = 32'h00001234;
`endif
    push1(32'h900, 4'b1111, 32'h99999999);
    push1(32'h300, 4'b0011, 32'h00001234);
    push1(32'h302, 4'b0100, 32'h00560000);
    #1;
    chk("t7_merge_count", 32'(count), 32'(e_cnt));
    chk("t7_head_addr", dm_addr, 32'h900);
    dm_ack = 1'b1;
    tick();
    chk("t7_entry_addr", dm_addr, 32'h300);
    chk("t7_entry_byteen", 32'(dm_byteen), 32'(e_be));
    chk("t7_entry_data", dm_wdata, e_d);
    repeat (3) tick();
    dm_ack = 1'b0;
    #1;
    chk("t7_drained", 32'(count), 32'd0);

    // Same sequence into an empty queue: the youngest is the head, so no merge.
    push1(32'h300, 4'b0011, 32'h00001234);
    push1(32'h302, 4'b0100, 32'h00560000);
    #1;
    chk("t8_count", 32'(count), 32'd2);
    chk("t8_head_byteen", 32'(dm_byteen), 32'h3);
    chk("t8_head_data", dm_wdata, 32'h00001234);
    dm_ack = 1'b1;
    repeat (3) tick();
    dm_ack = 1'b0;
    tick();
    chk("t8_drained", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
